// File: rtl/strobe_decim.sv
// strobe_decim: programmable strobe decimator.
// Forwards one qualifying strobe_in out of every (rate+1) as a one-clock
// strobe_out pulse. init reloads the down-counter from rate so the first
// output pulse lands a deterministic (rate+1) strobes later.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high reset
//   enable     counting enable; when low strobe_in is ignored, strobe_out is 0
//   init       reload counter from rate, restart decimation phase
//   strobe_in  input strobe; one event per enabled clock with strobe_in=1
//   rate       decimation rate: 0 passes every strobe, N every (N+1)th
//   strobe_out registered decimated strobe
//   count      (only with STROBE_DECIM_COUNT_OUT_EN) current counter value
//
// Optional feature macro: STROBE_DECIM_COUNT_OUT_EN
module strobe_decim #(
   parameter int unsigned RATE_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  init,
   input  logic                  strobe_in,
   input  logic [RATE_WIDTH-1:0] rate,
`ifdef STROBE_DECIM_COUNT_OUT_EN
   output logic [RATE_WIDTH-1:0] count,
`endif
   output logic                  strobe_out
);

   logic [RATE_WIDTH-1:0] cnt;
   logic [RATE_WIDTH-1:0] cnt_nxt;
   logic                  strobe_nxt;

   // Next-state: init wins over counting; a strobe with init is not counted.
   always_comb begin
      cnt_nxt    = cnt;
      strobe_nxt = 1'b0;
      if (init) begin
         cnt_nxt = rate;
      end else if (enable && strobe_in) begin
         if (cnt == '0) begin
            // Terminal count: pass this strobe and reload (rate sampled here).
            strobe_nxt = 1'b1;
            cnt_nxt    = rate;
         end else begin
            cnt_nxt = cnt - RATE_WIDTH'(1);
         end
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt        <= '0;
         strobe_out <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         strobe_out <= strobe_nxt;
      end
   end

`ifdef STROBE_DECIM_COUNT_OUT_EN
   assign count = cnt;
`endif

endmodule

// File: tb/tb_strobe_decim.sv
// Directed self-checking bench for strobe_decim.
module tb_strobe_decim;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       init = 1'b0;
   logic       strobe_in = 1'b0;
   logic [7:0] rate = 8'd0;
   logic       strobe_out;
`ifdef STROBE_DECIM_COUNT_OUT_EN
   logic [7:0] count;
`endif

   int checks = 0;
   int failures = 0;

   strobe_decim #(.RATE_WIDTH(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .init       (init),
      .strobe_in  (strobe_in),
      .rate       (rate),
`ifdef STROBE_DECIM_COUNT_OUT_EN
      .count      (count),
`endif
      .strobe_out (strobe_out)
   );

   always #5 clock = ~clock;

   // Apply inputs, advance one rising edge, settle before sampling.
   task automatic step(input logic ini, input logic en, input logic sin);
      init      = ini;
      enable    = en;
      strobe_in = sin;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [7:0] exp);
`ifdef STROBE_DECIM_COUNT_OUT_EN
      chk(tag, count, exp);
`else
      if (exp === 8'hxx) $display("unused");
`endif
   endtask

   initial begin
      // Reset
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("reset_out", {7'd0, strobe_out}, 8'd0);
      chk_cnt("reset_cnt", 8'd0);
      reset = 1'b0;

      // rate=2: pulses on clocks 3,6,9 of continuous strobes
      rate = 8'd2;
      step(1'b1, 1'b0, 1'b0);
      chk("r2_init_out", {7'd0, strobe_out}, 8'd0);
      chk_cnt("r2_init_cnt", 8'd2);
      for (int i = 1; i <= 9; i++) begin
         step(1'b0, 1'b1, 1'b1);
         chk($sformatf("r2_out_%0d", i), {7'd0, strobe_out}, (i % 3 == 0) ? 8'd1 : 8'd0);
         chk_cnt($sformatf("r2_cnt_%0d", i), 8'(2 - (i % 3)));
      end

      // rate=0: every strobe passes
      rate = 8'd0;
      step(1'b1, 1'b1, 1'b1);
      chk("r0_init_out", {7'd0, strobe_out}, 8'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b1);
         chk($sformatf("r0_const_%0d", i), {7'd0, strobe_out}, 8'd1);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
         chk($sformatf("r0_toggle_%0d", i), {7'd0, strobe_out}, (i % 2 == 0) ? 8'd1 : 8'd0);
      end

      // rate=3, strobes every other clock: one pulse per 4 strobes (8 clocks)
      rate = 8'd3;
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
         chk($sformatf("r3_sparse_%0d", i), {7'd0, strobe_out}, (i == 6 || i == 14) ? 8'd1 : 8'd0);
      end

      // rate=4: 2 strobes, disabled 5 clocks (count held), then 3 more
      rate = 8'd4;
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("r4_pre", {7'd0, strobe_out}, 8'd0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1);
         chk($sformatf("r4_dis_%0d", i), {7'd0, strobe_out}, 8'd0);
      end
      chk_cnt("r4_held_cnt", 8'd2);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1);
         chk($sformatf("r4_resume_%0d", i), {7'd0, strobe_out}, (i == 2) ? 8'd1 : 8'd0);
      end

      // rate=5 mid-count re-init with rate=1
      rate = 8'd5;
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
      chk_cnt("r5_mid_cnt", 8'd2);
      rate = 8'd1;
      step(1'b1, 1'b1, 1'b1);
      chk("reinit_out", {7'd0, strobe_out}, 8'd0);
      chk_cnt("reinit_cnt", 8'd1);
      step(1'b0, 1'b1, 1'b1);
      chk("reinit_s1", {7'd0, strobe_out}, 8'd0);
      step(1'b0, 1'b1, 1'b1);
      chk("reinit_s2", {7'd0, strobe_out}, 8'd1);

      // reset while strobe_out high, with init also high
      rate  = 8'd7;
      reset = 1'b1;
      step(1'b1, 1'b1, 1'b1);
      chk("rst_init_out", {7'd0, strobe_out}, 8'd0);
      chk_cnt("rst_init_cnt", 8'd0);
      reset = 1'b0;

      // no init after reset: first strobe passes, then period rate+1;
      // rate change mid-count applies only at the next reload
      step(1'b0, 1'b1, 1'b1);
      chk("noinit_first", {7'd0, strobe_out}, 8'd1);
      chk_cnt("noinit_reload", 8'd7);
      rate = 8'd1;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b1);
         chk($sformatf("ratechg_%0d", i), {7'd0, strobe_out}, (i == 7) ? 8'd1 : 8'd0);
      end
      step(1'b0, 1'b1, 1'b1);
      chk("newrate_0", {7'd0, strobe_out}, 8'd0);
      step(1'b0, 1'b1, 1'b1);
      chk("newrate_1", {7'd0, strobe_out}, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
